// File: rtl/uart_tx.sv
// uart_tx: serial transmitter with show-ahead FIFO pop, LSB-first data and two stop bits
module uart_tx #(
  parameter int SIZE_DATA   = 8,
  parameter int OVER_SAMPLE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stick,
  input  logic                 i_tx_en,
  input  logic                 i_fifo_empty,
  input  logic [SIZE_DATA-1:0] i_tx_data,
  output logic                 o_fifo_rd,
  output logic                 o_tx_data,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);
  localparam int CW = $clog2(OVER_SAMPLE) + 1;
  localparam int IW = $clog2(SIZE_DATA);
  typedef enum logic [2:0] {IDLE, START, TRANSMIT, STOP_I, STOP_II, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [SIZE_DATA-1:0] sh, sh_n;
  logic bit_end, tx_n;
  assign bit_end = i_stick && (cnt == CW'(OVER_SAMPLE - 1));
  assign o_tx_busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    sh_n = sh;
    case (state)
      IDLE: if (i_tx_en && !i_fifo_empty) begin
        state_n = START;
        sh_n = i_tx_data;
        cnt_n = '0;
        idx_n = '0;
      end
      START: state_n = bit_end ? TRANSMIT : START;
      TRANSMIT: if (bit_end) begin
        idx_n = idx + 1'b1;
        state_n = (idx == IW'(SIZE_DATA - 1)) ? STOP_I : TRANSMIT;
      end
      STOP_I: state_n = bit_end ? STOP_II : STOP_I;
      STOP_II: state_n = bit_end ? DONE : STOP_II;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // ticks only advance the bit timer while a bit is actually on the line
    if (i_stick && (state == START || state == TRANSMIT || state == STOP_I || state == STOP_II))
      cnt_n = bit_end ? '0 : cnt + 1'b1;
    tx_n = (state_n == TRANSMIT) ? sh_n[idx_n] : (state_n != START);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      o_tx_data <= 1'b1;
      o_fifo_rd <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      o_tx_data <= tx_n;
      o_fifo_rd <= (state == IDLE) && (state_n == START);
      o_tx_done <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized frame checks of uart_tx against a tick-level line model
module tb_uart_tx;
  logic i_clk = 0, i_rst, i_stick, i_tx_en, i_fifo_empty;
  logic [7:0] i_tx_data;
  logic o_fifo_rd, o_tx_data, o_tx_busy, o_tx_done;
  int checks = 0, errors = 0;
  int cyc = 0, rd_cnt = 0, done_cnt = 0;
  int stick_per = 4, ph = 0;
  bit stick_pause = 0, hold_data = 0;
  logic [7:0] q[$];

  uart_tx dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stick(i_stick), .i_tx_en(i_tx_en),
    .i_fifo_empty(i_fifo_empty), .i_tx_data(i_tx_data), .o_fifo_rd(o_fifo_rd),
    .o_tx_data(o_tx_data), .o_tx_busy(o_tx_busy), .o_tx_done(o_tx_done)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    rd_cnt <= rd_cnt + int'(o_fifo_rd);
    done_cnt <= done_cnt + int'(o_tx_done);
  end

  initial begin
    i_stick = 0;
    forever begin
      @(posedge i_clk);
      #2;
      ph = ph + 1;
      i_stick = !stick_pause && ph >= stick_per;
      if (i_stick) ph = 0;
    end
  end

  // show-ahead FIFO model: head word visible, popped on the strobe
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_fifo_rd === 1'b1 && q.size() > 0) void'(q.pop_front());
      i_fifo_empty = q.size() == 0;
      if (!hold_data) i_tx_data = (q.size() > 0) ? q[0] : 8'h00;
    end
  end

  function automatic logic [175:0] exp_levels(input logic [7:0] w);
    logic [175:0] r;
    logic [10:0] s;
    s = {2'b11, w, 1'b0};
    for (int t = 0; t < 176; t++) r[t] = s[t / 16];
    return r;
  endfunction

  task automatic capture(output logic [175:0] lv, output bit ok, output int sc);
    int n, t;
    n = 0; t = 0; lv = '1; sc = 0;
    do begin @(negedge i_clk); t++; end
    while (!(o_tx_busy === 1'b1 && o_tx_data === 1'b0) && t < 5000);
    sc = cyc;
    while (n < 176 && t < 20000) begin
      if (i_stick) begin lv[n] = o_tx_data; n++; end
      @(negedge i_clk);
      t++;
    end
    ok = n == 176;
  endtask

  task automatic wait_busy();
    int t;
    t = 0;
    while (o_tx_busy !== 1'b1 && t < 5000) begin @(negedge i_clk); t++; end
    checks++;
    if (o_tx_busy !== 1'b1) begin errors++; $display("FAIL frame_start: busy=%b required 1", o_tx_busy); end
  endtask

  task automatic test_reset();
    i_rst = 1; i_tx_en = 1; q.push_back(8'h5A);
    repeat (5) @(negedge i_clk);
    checks += 4;
    if (o_tx_data !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b required 1", o_tx_data); end
    if (o_tx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", o_tx_busy); end
    if (o_fifo_rd !== 1'b0) begin errors++; $display("FAIL rst_rd: got %b required 0", o_fifo_rd); end
    if (o_tx_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", o_tx_done); end
    i_tx_en = 0; q.delete();
    @(negedge i_clk); i_rst = 0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_basic();
    logic [175:0] lv; bit ok; int sc, rd0, d0;
    stick_per = 4; rd0 = rd_cnt; d0 = done_cnt;
    q.push_back(8'hA5); i_tx_en = 1;
    capture(lv, ok, sc);
    i_tx_en = 0;
    checks += 3;
    if (!ok) begin errors++; $display("FAIL basic_ticks: frame incomplete"); end
    if (lv !== exp_levels(8'hA5)) begin errors++; $display("FAIL basic_line: got %h required %h", lv, exp_levels(8'hA5)); end
    if (o_tx_done !== 1'b1) begin errors++; $display("FAIL basic_done_at_176: got %b required 1", o_tx_done); end
    @(negedge i_clk);
    checks++;
    if (o_tx_done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b required 0", o_tx_done); end
    repeat (5) @(negedge i_clk);
    checks += 2;
    if (rd_cnt - rd0 != 1) begin errors++; $display("FAIL basic_rd_count: got %0d required 1", rd_cnt - rd0); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_empty_idle();
    int bad, rd0;
    bad = 0; rd0 = rd_cnt; i_tx_en = 1;
    repeat (1000) begin
      @(negedge i_clk);
      if (o_tx_data !== 1'b1 || o_fifo_rd !== 1'b0 || o_tx_busy !== 1'b0 || o_tx_done !== 1'b0) bad++;
    end
    i_tx_en = 0;
    checks += 2;
    if (bad != 0) begin errors++; $display("FAIL empty_idle: %0d bad cycles required 0", bad); end
    if (rd_cnt != rd0) begin errors++; $display("FAIL empty_rd: got %0d pops required 0", rd_cnt - rd0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w[3];
    logic [175:0] lv; bit ok; int sc, dc, rd0, d0;
    w = '{8'h00, 8'hFF, 8'h3C};
    stick_per = $urandom_range(2, 6); rd0 = rd_cnt; d0 = done_cnt; dc = 0;
    for (int k = 0; k < 3; k++) q.push_back(w[k]);
    i_tx_en = 1;
    for (int k = 0; k < 3; k++) begin
      capture(lv, ok, sc);
      checks += 3;
      if (!ok) begin errors++; $display("FAIL b2b_ticks[%0d]: frame incomplete", k); end
      if (lv !== exp_levels(w[k])) begin errors++; $display("FAIL b2b_line[%0d]: got %h required %h", k, lv, exp_levels(w[k])); end
      if (o_tx_done !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d]: got %b required 1", k, o_tx_done); end
      if (k > 0) begin
        checks++;
        if (sc - dc != 2) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d cycles required 2", k, sc - dc); end
      end
      dc = cyc;
    end
    i_tx_en = 0;
    repeat (5) @(negedge i_clk);
    checks += 2;
    if (rd_cnt - rd0 != 3) begin errors++; $display("FAIL b2b_rd_count: got %0d required 3", rd_cnt - rd0); end
    if (done_cnt - d0 != 3) begin errors++; $display("FAIL b2b_done_count: got %0d required 3", done_cnt - d0); end
  endtask

  task automatic test_random();
    logic [175:0] lv; bit ok; int sc;
    logic [7:0] w;
    for (int k = 0; k < 6; k++) begin
      w = 8'($urandom); stick_per = $urandom_range(2, 6);
      repeat ($urandom_range(1, 30)) @(negedge i_clk);
      q.push_back(w); i_tx_en = 1;
      capture(lv, ok, sc);
      i_tx_en = 0;
      checks += 2;
      if (!ok || lv !== exp_levels(w)) begin errors++; $display("FAIL rand_line[%0d] w=%h per=%0d: got %h required %h", k, w, stick_per, lv, exp_levels(w)); end
      if (o_tx_done !== 1'b1) begin errors++; $display("FAIL rand_done[%0d]: got %b required 1", k, o_tx_done); end
    end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_enable_drop();
    logic [175:0] lv; bit ok; int sc, rd0, d0, busy_seen;
    stick_per = 4; rd0 = rd_cnt; d0 = done_cnt; busy_seen = 0;
    q.push_back(8'h81); i_tx_en = 1;
    fork
      capture(lv, ok, sc);
      begin
        wait_busy();
        repeat ((4 * 16 + 8) * 4) @(negedge i_clk);
        hold_data = 1; i_tx_data = 8'h00; i_tx_en = 0; q.push_back(8'h55);
      end
    join
    checks++;
    if (!ok || lv !== exp_levels(8'h81)) begin errors++; $display("FAIL drop_line: got %h required %h", lv, exp_levels(8'h81)); end
    @(negedge i_clk);
    repeat (300) begin @(negedge i_clk); if (o_tx_busy !== 1'b0 || o_tx_data !== 1'b1) busy_seen++; end
    checks += 3;
    if (busy_seen != 0) begin errors++; $display("FAIL drop_no_restart: %0d busy cycles required 0", busy_seen); end
    if (rd_cnt - rd0 != 1) begin errors++; $display("FAIL drop_rd_count: got %0d required 1", rd_cnt - rd0); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL drop_done_count: got %0d required 1", done_cnt - d0); end
    q.delete(); hold_data = 0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_reset_mid();
    logic [175:0] lv; bit ok; int sc, rd0, d0;
    logic [7:0] w;
    stick_per = 4; w = 8'($urandom) & 8'hDF;
    q.push_back(w); i_tx_en = 1;
    wait_busy();
    repeat ((6 * 16 + 8) * 4 - 2) @(negedge i_clk);
    checks++;
    if (o_tx_data !== 1'b0) begin errors++; $display("FAIL mid_bit5_level: got %b required 0", o_tx_data); end
    rd0 = rd_cnt; d0 = done_cnt;
    @(posedge i_clk); #3;
    i_rst = 1; i_tx_en = 0;
    #1;
    checks += 4;
    if (o_tx_data !== 1'b1) begin errors++; $display("FAIL mid_rst_tx: got %b required 1", o_tx_data); end
    if (o_tx_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b required 0", o_tx_busy); end
    if (o_fifo_rd !== 1'b0) begin errors++; $display("FAIL mid_rst_rd: got %b required 0", o_fifo_rd); end
    if (o_tx_done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b required 0", o_tx_done); end
    repeat (3) @(negedge i_clk);
    i_rst = 0;
    repeat (20) @(negedge i_clk);
    checks += 2;
    if (rd_cnt != rd0) begin errors++; $display("FAIL mid_rst_pop: got %0d pops required 0", rd_cnt - rd0); end
    if (done_cnt != d0) begin errors++; $display("FAIL mid_rst_done_pulse: got %0d required 0", done_cnt - d0); end
    w = 8'($urandom);
    q.push_back(w); i_tx_en = 1;
    capture(lv, ok, sc);
    i_tx_en = 0;
    checks++;
    if (!ok || lv !== exp_levels(w)) begin errors++; $display("FAIL mid_rst_next: got %h required %h", lv, exp_levels(w)); end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_stick_pause();
    logic [175:0] lv; bit ok; int sc, changes;
    logic lvl;
    logic [7:0] w;
    stick_per = 4; w = 8'($urandom); changes = 0;
    q.push_back(w); i_tx_en = 1;
    fork
      capture(lv, ok, sc);
      begin
        wait_busy();
        repeat (16 * 4 + 24) @(negedge i_clk);
        stick_pause = 1;
        @(negedge i_clk);
        lvl = o_tx_data;
        repeat (50) begin
          @(negedge i_clk);
          if (o_tx_data !== lvl || o_tx_busy !== 1'b1 || o_tx_done !== 1'b0) changes++;
        end
        stick_pause = 0;
      end
    join
    i_tx_en = 0;
    checks += 2;
    if (changes != 0) begin errors++; $display("FAIL pause_frozen: %0d changes required 0", changes); end
    if (!ok || lv !== exp_levels(w)) begin errors++; $display("FAIL pause_line: got %h required %h", lv, exp_levels(w)); end
    repeat (3) @(negedge i_clk);
  endtask

  initial begin
    i_rst = 1; i_tx_en = 0; i_fifo_empty = 1; i_tx_data = 0;
    test_reset();
    test_basic();
    test_empty_idle();
    test_back_to_back();
    test_random();
    test_enable_drop();
    test_reset_mid();
    test_stick_pause();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
